// File: rtl/mem_mover_pkg.sv
// Shared types and constants for the memory block mover.
package mem_mover_pkg;

    // Controller states: idle, read a source byte, write a destination byte, completion pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } mover_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover.sv
// Block copy / fill engine that drives the data memory's single port while busy.
// Copies walk backward when the destination overlaps the tail of the source, so
// overlapping moves always reproduce the original source image.
module mem_block_mover
    import mem_mover_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic [DW-1:0] mem_dat_out,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] ONE = AW'(1);

    mover_state_t  state;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] count;
    logic [DW-1:0] data_buf;
    logic          mode_r;
    logic [DW-1:0] fill_r;
    logic          backward;

    logic [AW-1:0] start_diff;
    logic [AW-1:0] len_m1;
    logic          start_back;
    logic          start_noop;

    // Request decode: a copy runs backward when dst lands inside (src, src+len)
    assign start_diff = dst - src;
    assign len_m1     = len - ONE;
    assign start_back = (mode == MODE_COPY) && (start_diff != '0) && (start_diff < len);
    assign start_noop = (len == '0) || ((mode == MODE_COPY) && (src == dst));

    // Sequencer: state, pointers, remaining count and the read-data holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_buf <= '0;
            mode_r   <= MODE_COPY;
            fill_r   <= '0;
            backward <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        fill_r   <= fill_val;
                        count    <= len;
                        backward <= start_back;
                        rd_ptr   <= start_back ? (src + len_m1) : src;
                        wr_ptr   <= start_back ? (dst + len_m1) : dst;
                        if (start_noop) begin
                            state <= FIN;
                        end else if (mode == MODE_COPY) begin
                            state <= RD;
                        end else begin
                            state <= WR;
                        end
                    end
                end
                RD: begin
                    data_buf <= mem_dat_out;
                    state    <= WR;
                end
                WR: begin
                    count  <= count - ONE;
                    rd_ptr <= backward ? (rd_ptr - ONE) : (rd_ptr + ONE);
                    wr_ptr <= backward ? (wr_ptr - ONE) : (wr_ptr + ONE);
                    if (count == ONE) begin
                        state <= FIN;
                    end else if (mode_r == MODE_COPY) begin
                        state <= RD;
                    end else begin
                        state <= WR;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port and status outputs decoded from the current state
    always_comb begin
        mem_addr   = '0;
        mem_wr_en  = 1'b0;
        mem_dat_in = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RD: begin
                mem_addr = rd_ptr;
                busy     = 1'b1;
            end
            WR: begin
                mem_addr   = wr_ptr;
                mem_wr_en  = 1'b1;
                mem_dat_in = (mode_r == MODE_FILL) ? fill_r : data_buf;
                busy       = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: the mover is wired to a 256-byte memory model,
// expected writes are queued by the stimulus and checked by a write monitor.
module tb_mem_block_mover;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic [7:0] mem_dat_out;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_dat_in;
    logic       busy;
    logic       done;

    logic       tb_wr;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;
    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec;
    int  n_bad;
    int  done_count;
    int  exp_done;

    mem_block_mover #(.AW(8), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .fill_val    (fill_val),
        .mem_dat_out (mem_dat_out),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_dat_in  (mem_dat_in),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge; bench port for preloading
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_dat_in;
        end else if (tb_wr) begin
            mem[tb_addr] <= tb_data;
        end
    end

    // Write monitor: every DUT write must match the next expected write
    always @(negedge clk) begin
        if (mem_wr_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_write: got addr=%02h data=%02h, required no write",
                         mem_addr, mem_dat_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_dat_in !== e.data) begin
                    n_bad++;
                    $display("[TB] FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             mem_addr, mem_dat_in, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) done_count++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic pushWrite(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_wr   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk); #1;
        tb_wr   = 1'b0;
    endtask

    task automatic issueStart(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l, input logic [7:0] f);
        mode     = m;
        src      = s;
        dst      = d;
        len      = l;
        fill_val = f;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic waitDone(input string name, output int cycles);
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) cycles++;
        end
        checkOutput({name, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        checkOutput({name, "_done_width"}, int'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input string name, input logic m, input logic [7:0] s,
                                 input logic [7:0] d, input logic [7:0] l, input logic [7:0] f,
                                 input int exp_busy);
        int cyc;
        exp_done++;
        issueStart(m, s, d, l, f);
        waitDone(name, cyc);
        checkOutput({name, "_busy_cycles"}, cyc, exp_busy);
    endtask

    initial begin
        int cyc;
        n_vec      = 0;
        n_bad      = 0;
        done_count = 0;
        exp_done   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        src        = '0;
        dst        = '0;
        len        = '0;
        fill_val   = '0;
        tb_wr      = 1'b0;
        tb_addr    = '0;
        tb_data    = '0;

        for (int a = 0; a < 256; a++) poke(8'(a), 8'h00);

        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_wr_en", int'(mem_wr_en), 0);
        checkOutput("reset_addr", int'(mem_addr), 0);
        checkOutput("reset_dat_in", int'(mem_dat_in), 0);

        // start together with reset must be dropped
        issueStart(1'b1, 8'h00, 8'hC0, 8'h01, 8'h99);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("start_with_reset_busy", int'(busy), 0);
        checkOutput("start_with_reset_done", int'(done), 0);
        @(posedge clk); #1;

        $display("[TB] forward copy");
        poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
        poke(8'h24, 8'h77);
        pushWrite(8'h20, 8'hAA); pushWrite(8'h21, 8'hBB);
        pushWrite(8'h22, 8'hCC); pushWrite(8'h23, 8'hDD);
        applyStimulus("fwd", 1'b0, 8'h10, 8'h20, 8'h04, 8'h00, 8);
        checkOutput("fwd_mem20", int'(mem[8'h20]), 'hAA);
        checkOutput("fwd_mem23", int'(mem[8'h23]), 'hDD);
        checkOutput("fwd_mem24", int'(mem[8'h24]), 'h77);

        $display("[TB] overlapping copy");
        poke(8'h40, 8'h01); poke(8'h41, 8'h02); poke(8'h42, 8'h03); poke(8'h43, 8'h04);
        pushWrite(8'h44, 8'h04); pushWrite(8'h43, 8'h03);
        pushWrite(8'h42, 8'h02); pushWrite(8'h41, 8'h01);
        applyStimulus("ovl", 1'b0, 8'h40, 8'h41, 8'h04, 8'h00, 8);
        checkOutput("ovl_mem40", int'(mem[8'h40]), 'h01);
        checkOutput("ovl_mem41", int'(mem[8'h41]), 'h01);
        checkOutput("ovl_mem42", int'(mem[8'h42]), 'h02);
        checkOutput("ovl_mem44", int'(mem[8'h44]), 'h04);

        $display("[TB] fill with wrap");
        poke(8'h02, 8'h33);
        pushWrite(8'hFE, 8'h5A); pushWrite(8'hFF, 8'h5A);
        pushWrite(8'h00, 8'h5A); pushWrite(8'h01, 8'h5A);
        applyStimulus("fill", 1'b1, 8'h00, 8'hFE, 8'h04, 8'h5A, 4);
        checkOutput("fill_memFF", int'(mem[8'hFF]), 'h5A);
        checkOutput("fill_mem00", int'(mem[8'h00]), 'h5A);
        checkOutput("fill_mem02", int'(mem[8'h02]), 'h33);

        $display("[TB] degenerate requests");
        applyStimulus("len0", 1'b1, 8'h00, 8'h30, 8'h00, 8'hEE, 0);
        applyStimulus("same", 1'b0, 8'h30, 8'h30, 8'h03, 8'h00, 0);

        $display("[TB] reset mid-operation");
        poke(8'h50, 8'h11); poke(8'h51, 8'h22); poke(8'h52, 8'h33); poke(8'h53, 8'h44);
        pushWrite(8'h60, 8'h11);
        issueStart(1'b0, 8'h50, 8'h60, 8'h04, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_addr", int'(mem_addr), 0);
        checkOutput("rst_mem60", int'(mem[8'h60]), 'h11);
        checkOutput("rst_mem61", int'(mem[8'h61]), 'h00);
        pushWrite(8'h70, 8'hEE);
        applyStimulus("after_rst", 1'b1, 8'h00, 8'h70, 8'h01, 8'hEE, 1);
        checkOutput("after_rst_mem70", int'(mem[8'h70]), 'hEE);

        $display("[TB] start while busy");
        poke(8'h80, 8'h9A); poke(8'h81, 8'h9B); poke(8'h82, 8'h9C);
        pushWrite(8'h90, 8'h9A); pushWrite(8'h91, 8'h9B); pushWrite(8'h92, 8'h9C);
        exp_done++;
        issueStart(1'b0, 8'h80, 8'h90, 8'h03, 8'h00);
        issueStart(1'b1, 8'h00, 8'hA0, 8'h05, 8'hFF);
        // one of the six busy cycles elapsed before the wait began
        waitDone("busy_start", cyc);
        checkOutput("busy_start_cycles", cyc, 5);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_start_idle", int'(busy), 0);
        checkOutput("busy_start_mem92", int'(mem[8'h92]), 'h9C);
        checkOutput("busy_start_memA0", int'(mem[8'hA0]), 'h00);

        checkOutput("exp_queue_empty", exp_q.size(), 0);
        checkOutput("done_pulses", done_count, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
